alu_md: RTL and testbench

- Parametrised successor to the single-cycle datapath ALU.
- Combinational integer ALU with a wider op set, signed-overflow flag and corrected signed/unsigned compare.
- Adds an iterative multiply/divide unit with HI/LO registers and a start/busy/done handshake.
- Sits in the cpu datapath; controller stalls the pipeline on busy and reads hi/lo for mfhi/mflo.

---
 rtl/alu_md.sv | 161 ++++++++++++++++
 tb/tb_alu_md.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// Datapath ALU with signed-overflow detection, plus an iterative radix-2
// multiply/divide unit that writes a HI/LO register pair.
module alu_md #(
   parameter int N   = 32,
   parameter int SHW = $clog2(N)
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic [N-1:0] src1,
   input  logic [N-1:0] src2,
   input  logic [3:0]   alu_ctrl_sig,
   output logic [N-1:0] alu_out,
   output logic         zero,
   output logic         overflow,
   input  logic         md_start,
   input  logic [1:0]   md_op,
   input  logic         hilo_we,
   input  logic         hilo_sel,
   output logic         busy,
   output logic         md_done,
   output logic [N-1:0] hi,
   output logic [N-1:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   function automatic logic [N-1:0] cond_neg(input logic [N-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*N-1:0] cond_neg_w(input logic [2*N-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   logic signed [N-1:0] a_s, b_s, sum_s, dif_s;
   logic [SHW-1:0]      shamt;

   assign a_s   = src1;
   assign b_s   = src2;
   assign sum_s = a_s + b_s;
   assign dif_s = a_s - b_s;
   assign shamt = src2[SHW-1:0];

   always_comb begin
      alu_out  = '0;
      overflow = 1'b0;
      case (alu_ctrl_sig)
         4'h0: alu_out = src1 & src2;
         4'h1: alu_out = src1 | src2;
         4'h2: begin
            alu_out  = sum_s;
            overflow = (a_s[N-1] == b_s[N-1]) && (sum_s[N-1] != a_s[N-1]);
         end
         4'h3: alu_out = src1 ^ src2;
         4'h4: alu_out = src1 & ~src2;
         4'h5: alu_out = src1 | ~src2;
         4'h6: begin
            alu_out  = dif_s;
            overflow = (a_s[N-1] != b_s[N-1]) && (dif_s[N-1] != a_s[N-1]);
         end
         4'h7: alu_out = {{(N-1){1'b0}}, (a_s < b_s)};
         4'h8: alu_out = {{(N-1){1'b0}}, (src1 < src2)};
         4'h9: alu_out = src1 << shamt;
         4'hA: alu_out = src1 >> shamt;
         4'hB: alu_out = a_s >>> shamt;
         4'hC: alu_out = ~(src1 | src2);
         default: alu_out = '0;
      endcase
   end

   assign zero = (alu_out == '0);

   // Mul/div engine: acc holds the high half / partial remainder, mq the
   // multiplier shifting out / quotient shifting in.
   state_t         state;
   logic [SHW-1:0] cnt;
   logic [N-1:0]   acc, mq, mcand;
   logic           is_div, qneg, rneg, dz;

   logic           sgn_op;
   logic [N-1:0]   abs1, abs2;
   logic [N:0]     mul_sum, div_sh, div_diff;
   logic           div_ge;

   assign sgn_op   = ~md_op[0];
   assign abs1     = cond_neg(src1, sgn_op & src1[N-1]);
   assign abs2     = cond_neg(src2, sgn_op & src2[N-1]);
   assign mul_sum  = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
   assign div_sh   = {acc, mq[N-1]};
   assign div_diff = div_sh - {1'b0, mcand};
   assign div_ge   = (div_sh >= {1'b0, mcand});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         busy    <= 1'b0;
         md_done <= 1'b0;
         hi      <= '0;
         lo      <= '0;
         cnt     <= '0;
         acc     <= '0;
         mq      <= '0;
         mcand   <= '0;
         is_div  <= 1'b0;
         qneg    <= 1'b0;
         rneg    <= 1'b0;
         dz      <= 1'b0;
      end else begin
         md_done <= 1'b0;
         case (state)
            IDLE: begin
               if (md_start) begin
                  state  <= RUN;
                  busy   <= 1'b1;
                  cnt    <= SHW'(N-1);
                  is_div <= md_op[1];
                  qneg   <= sgn_op & (src1[N-1] ^ src2[N-1]);
                  rneg   <= sgn_op & src1[N-1];
                  dz     <= (src2 == '0);
                  acc    <= '0;
                  if (md_op[1]) begin
                     mq    <= abs1;
                     mcand <= abs2;
                  end else begin
                     mq    <= abs2;
                     mcand <= abs1;
                  end
               end else if (hilo_we) begin
                  if (hilo_sel) hi <= src1;
                  else          lo <= src1;
               end
            end
            RUN: begin
               if (is_div) begin
                  acc <= div_ge ? div_diff[N-1:0] : div_sh[N-1:0];
                  mq  <= {mq[N-2:0], div_ge};
               end else begin
                  acc <= mul_sum[N:1];
                  mq  <= {mul_sum[0], mq[N-1:1]};
               end
               if (cnt == '0) state <= FIX;
               else           cnt   <= cnt - SHW'(1);
            end
            FIX: begin
               // Divide by zero leaves the dividend in acc, so only lo needs forcing.
               if (is_div) begin
                  lo <= dz ? '1 : cond_neg(mq, qneg);
                  hi <= cond_neg(acc, rneg);
               end else begin
                  {hi, lo} <= cond_neg_w({acc, mq}, qneg);
               end
               state   <= IDLE;
               busy    <= 1'b0;
               md_done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_md.sv
// Directed bench for alu_md (N=32): ALU vectors, HI/LO writes, mul/div
// latency and results, busy-time ignores and asynchronous reset.
module tb_alu_md;

   localparam int N = 32;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [N-1:0]  src1, src2;
   logic [3:0]    alu_ctrl_sig;
   logic [N-1:0]  alu_out;
   logic          zero, overflow;
   logic          md_start;
   logic [1:0]    md_op;
   logic          hilo_we, hilo_sel;
   logic          busy, md_done;
   logic [N-1:0]  hi, lo;

   int checks = 0;
   int errors = 0;

   alu_md #(.N(N)) dut (
      .clk(clk), .reset_n(reset_n), .src1(src1), .src2(src2),
      .alu_ctrl_sig(alu_ctrl_sig), .alu_out(alu_out), .zero(zero),
      .overflow(overflow), .md_start(md_start), .md_op(md_op),
      .hilo_we(hilo_we), .hilo_sel(hilo_sel), .busy(busy),
      .md_done(md_done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]   c;
      logic [31:0]  a;
      logic [31:0]  b;
      logic [31:0]  r;
      logic         ov;
   } vec_t;

   task automatic test_reset();
      reset_n = 1'b0; src1 = '0; src2 = '0; alu_ctrl_sig = '0;
      md_start = 1'b0; md_op = '0; hilo_we = 1'b0; hilo_sel = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
      checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL reset_done got %h want 0", md_done); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_alu();
      vec_t v[22];
      v[0]  = '{4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1};
      v[1]  = '{4'h6, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1};
      v[2]  = '{4'h7, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0};
      v[3]  = '{4'h8, 32'h80000000, 32'h00000001, 32'h00000000, 1'b0};
      v[4]  = '{4'hB, 32'hF0000000, 32'h00000004, 32'hFF000000, 1'b0};
      v[5]  = '{4'h6, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
      v[6]  = '{4'h0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
      v[7]  = '{4'h1, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0};
      v[8]  = '{4'h3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0};
      v[9]  = '{4'h4, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, 1'b0};
      v[10] = '{4'h5, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF0FFF0FF, 1'b0};
      v[11] = '{4'hC, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0};
      v[12] = '{4'h9, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0};
      v[13] = '{4'h9, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0};
      v[14] = '{4'hA, 32'hF0000000, 32'h00000004, 32'h0F000000, 1'b0};
      v[15] = '{4'h2, 32'h00000001, 32'h00000002, 32'h00000003, 1'b0};
      v[16] = '{4'h2, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
      v[17] = '{4'hD, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0};
      v[18] = '{4'h7, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b0};
      v[19] = '{4'h7, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
      v[20] = '{4'h6, 32'h00000000, 32'h80000000, 32'h80000000, 1'b1};
      v[21] = '{4'h3, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0};
      for (int i = 0; i < 22; i++) begin
         alu_ctrl_sig = v[i].c; src1 = v[i].a; src2 = v[i].b;
         #1;
         checks++;
         if (alu_out !== v[i].r) begin
            errors++; $display("FAIL alu_out[%0d] op %h got %h want %h", i, v[i].c, alu_out, v[i].r);
         end
         checks++;
         if (overflow !== v[i].ov) begin
            errors++; $display("FAIL alu_ovf[%0d] op %h got %h want %h", i, v[i].c, overflow, v[i].ov);
         end
         checks++;
         if (zero !== (v[i].r == 32'h0)) begin
            errors++; $display("FAIL alu_zero[%0d] op %h got %h want %h", i, v[i].c, zero, (v[i].r == 32'h0));
         end
      end
      alu_ctrl_sig = '0; src1 = '0; src2 = '0;
      @(negedge clk);
   endtask

   task automatic test_hilo();
      hilo_we = 1'b1; hilo_sel = 1'b1; src1 = 32'hDEADBEEF;
      @(negedge clk);
      hilo_we = 1'b0;
      checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi_hi got %h want DEADBEEF", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mthi_lo got %h want 0", lo); end
      hilo_we = 1'b1; hilo_sel = 1'b0; src1 = 32'h12345678;
      @(negedge clk);
      hilo_we = 1'b0;
      checks++; if (lo !== 32'h12345678) begin errors++; $display("FAIL mtlo_lo got %h want 12345678", lo); end
      checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mtlo_hi got %h want DEADBEEF", hi); end
   endtask

   task automatic run_md(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input string nm);
      int bad;
      src1 = a; src2 = b; md_op = op; md_start = 1'b1;
      @(negedge clk);
      md_start = 1'b0; src1 = 32'h55555555; src2 = 32'hAAAAAAAA; md_op = ~op;
      bad = 0;
      for (int i = 0; i < N + 1; i++) begin
         if (busy !== 1'b1 || md_done !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL %s_busy_window bad cycles %0d want 0", nm, bad); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end got %h want 0", nm, busy); end
      checks++; if (md_done !== 1'b1) begin errors++; $display("FAIL %s_done got %h want 1", nm, md_done); end
      checks++; if (hi !== eh) begin errors++; $display("FAIL %s_hi got %h want %h", nm, hi, eh); end
      checks++; if (lo !== el) begin errors++; $display("FAIL %s_lo got %h want %h", nm, lo, el); end
      @(negedge clk);
      checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL %s_done_pulse got %h want 0", nm, md_done); end
   endtask

   task automatic test_mul();
      run_md(2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_m3x5");
      run_md(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, "multu_max");
      run_md(2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, "mult_minmin");
   endtask

   task automatic test_div();
      run_md(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100_7");
      run_md(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2");
      run_md(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, "div_min_m1");
      run_md(2'b11, 32'd1234, 32'd0, 32'h000004D2, 32'hFFFFFFFF, "divu_by0");
      run_md(2'b10, 32'hFFFFFB2E, 32'd0, 32'hFFFFFB2E, 32'hFFFFFFFF, "div_neg_by0");
   endtask

   task automatic test_busy_ignore();
      int n;
      // start and mtlo in the same cycle: the write must be dropped
      src1 = 32'd5; src2 = 32'd3; md_op = 2'b01; md_start = 1'b1;
      hilo_we = 1'b1; hilo_sel = 1'b0;
      @(negedge clk);
      md_start = 1'b0; hilo_we = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ign_busy got %h want 1", busy); end
      checks++; if (lo !== 32'h12345678) begin errors++; $display("FAIL ign_same_cycle_lo got %h want 12345678", lo); end
      repeat (3) @(negedge clk);
      src1 = 32'h0000FFFF; src2 = 32'h0000FFFF; md_op = 2'b00; md_start = 1'b1;
      hilo_we = 1'b1; hilo_sel = 1'b1;
      @(negedge clk);
      md_start = 1'b0; hilo_we = 1'b0;
      checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL ign_busy_hi got %h want DEADBEEF", hi); end
      checks++; if (lo !== 32'h12345678) begin errors++; $display("FAIL ign_busy_lo got %h want 12345678", lo); end
      n = 5;
      while (md_done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++; if (n != N + 2) begin errors++; $display("FAIL ign_latency got %0d want %0d", n, N + 2); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ign_res_hi got %h want 0", hi); end
      checks++; if (lo !== 32'd15) begin errors++; $display("FAIL ign_res_lo got %h want f", lo); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart got %h want 0", busy); end
   endtask

   task automatic test_reset_mid();
      int bad;
      src1 = 32'd7; src2 = 32'd9; md_op = 2'b00; md_start = 1'b1;
      @(negedge clk);
      md_start = 1'b0;
      repeat (10) @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %h want 0", busy); end
      checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got %h want 0", md_done); end
      checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_mid_hi got %h want 0", hi); end
      checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_mid_lo got %h want 0", lo); end
      @(negedge clk);
      reset_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (md_done !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet bad cycles %0d want 0", bad); end
      run_md(2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult_after_rst");
   endtask

   initial begin
      test_reset();
      test_alu();
      test_hilo();
      test_busy_ignore();
      test_mul();
      test_div();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
